// File: rtl/mu_ram_1rw_arb.sv
// Single-port RAM front end: write/read request merge plus a 2-entry read response buffer.
// Optional round-robin arbitration when MU_RAM_ARB_RR_EN is defined (fixed write priority otherwise).
module mu_ram_1rw_arb #(
    parameter int DW = 8,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wr,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rd
);

    logic [1:0]    cnt_q, cnt_d;
    logic          inflight_q;
    logic          rp_q, wp_q;
    logic [DW-1:0] buf_q [2];
    logic [AW-1:0] addr_q;
    logic [2:0]    credits;
    logic          push, pop;
    logic          wr_ok, rd_ok;
    logic          wr_gnt, rd_gnt;

    assign credits   = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign rsp_valid = !rst && (cnt_q != 2'd0);
    assign rsp_data  = buf_q[rp_q];
    assign pop       = rsp_valid & rsp_ready;
    // RAM read data is valid the cycle after the read is issued
    assign push      = inflight_q & !rst;

    assign wr_ok = wr_valid & !rst;
    assign rd_ok = rd_valid & !rst & ((credits < 3'd2) | pop);

`ifdef MU_RAM_ARB_RR_EN
    logic last_rd_q;

    always_comb begin
        wr_gnt = wr_ok & (!rd_ok | last_rd_q);
        rd_gnt = rd_ok & !wr_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd_q <= 1'b0;
        end else if (wr_gnt || rd_gnt) begin
            last_rd_q <= rd_gnt;
        end
    end
`else
    always_comb begin
        wr_gnt = wr_ok;
        rd_gnt = rd_ok & !wr_ok;
    end
`endif

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;
    assign ram_we   = wr_gnt;
    assign ram_re   = rd_gnt;
    assign ram_wr   = wr_data;

    always_comb begin
        ram_addr = addr_q;
        if (wr_gnt) begin
            ram_addr = wr_addr;
        end else if (rd_gnt) begin
            ram_addr = rd_addr;
        end
    end

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            rp_q       <= 1'b0;
            wp_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= rd_gnt;
            addr_q     <= ram_addr;
            if (push) begin
                wp_q <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wp_q] <= ram_rd;
        end
    end

endmodule
